// File: rtl/wb_arb_pkg.sv
// Shared state encoding and bus-width constants for the two-master Wishbone BRAM arbiter.
package wb_arb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/wb_bram_arb2_if.sv
// Bundle of both Wishbone slave ports and the BRAM port; slave = arbiter view, master = environment view.
interface wb_bram_arb2_if #(
  parameter int MEM_AW = 9
);

  logic                          s0_cyc_i;
  logic                          s0_stb_i;
  logic                          s0_we_i;
  logic [31:0]                   s0_adr_i;
  logic [wb_arb_pkg::WB_SW-1:0]  s0_sel_i;
  logic [wb_arb_pkg::WB_DW-1:0]  s0_dat_i;
  logic [wb_arb_pkg::WB_DW-1:0]  s0_dat_o;
  logic                          s0_ack_o;
  logic                          s0_err_o;

  logic                          s1_cyc_i;
  logic                          s1_stb_i;
  logic                          s1_we_i;
  logic [31:0]                   s1_adr_i;
  logic [wb_arb_pkg::WB_SW-1:0]  s1_sel_i;
  logic [wb_arb_pkg::WB_DW-1:0]  s1_dat_i;
  logic [wb_arb_pkg::WB_DW-1:0]  s1_dat_o;
  logic                          s1_ack_o;
  logic                          s1_err_o;

  logic                          mem_en;
  logic [wb_arb_pkg::WB_SW-1:0]  mem_we;
  logic [MEM_AW-1:0]             mem_addr;
  logic [wb_arb_pkg::WB_DW-1:0]  mem_di;
  logic [wb_arb_pkg::WB_DW-1:0]  mem_do;

  modport slave (
    input  s0_cyc_i, s0_stb_i, s0_we_i, s0_adr_i, s0_sel_i, s0_dat_i,
    output s0_dat_o, s0_ack_o, s0_err_o,
    input  s1_cyc_i, s1_stb_i, s1_we_i, s1_adr_i, s1_sel_i, s1_dat_i,
    output s1_dat_o, s1_ack_o, s1_err_o,
    output mem_en, mem_we, mem_addr, mem_di,
    input  mem_do
  );

  modport master (
    output s0_cyc_i, s0_stb_i, s0_we_i, s0_adr_i, s0_sel_i, s0_dat_i,
    input  s0_dat_o, s0_ack_o, s0_err_o,
    output s1_cyc_i, s1_stb_i, s1_we_i, s1_adr_i, s1_sel_i, s1_dat_i,
    input  s1_dat_o, s1_ack_o, s1_err_o,
    input  mem_en, mem_we, mem_addr, mem_di,
    output mem_do
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; on a tie the port not granted last time wins.
// No grant is issued while en is low; losing requests are simply left pending.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) begin
        gnt = last_gnt ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/wb_bram_arb2.sv
// Two-master Wishbone front end for a single-port BRAM: one access per 3 clocks, ack/err in the
// cycle two edges after stb is sampled; a losing master keeps its strobe held until granted.
module wb_bram_arb2
  import wb_arb_pkg::*;
#(
  parameter int MEM_AW = 9
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  wb_bram_arb2_if.slave  bus
);

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic               we_q, we_d;
  logic               err_pend_q, err_pend_d;
  logic               mem_en_q, mem_en_d;
  logic [WB_SW-1:0]   mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [WB_DW-1:0]   mem_di_q, mem_di_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;

  logic [1:0]         req;
  logic [1:0]         gnt_oh;
  logic               sel_we;
  logic [31:0]        sel_adr;
  logic [WB_SW-1:0]   sel_sel;
  logic [WB_DW-1:0]   sel_dat;
  logic               in_range;
  logic               granted_cyc;
  logic [1:0]         unused_adr_lsb;

  assign req = {bus.s1_cyc_i & bus.s1_stb_i, bus.s0_cyc_i & bus.s0_stb_i};

  rr_arb2 u_rr_arb2 (
    .req      (req),
    .last_gnt (last_gnt_q),
    .en       (state_q == IDLE),
    .gnt      (gnt_oh)
  );

  assign sel_we         = gnt_oh[1] ? bus.s1_we_i  : bus.s0_we_i;
  assign sel_adr        = gnt_oh[1] ? bus.s1_adr_i : bus.s0_adr_i;
  assign sel_sel        = gnt_oh[1] ? bus.s1_sel_i : bus.s0_sel_i;
  assign sel_dat        = gnt_oh[1] ? bus.s1_dat_i : bus.s0_dat_i;
  assign in_range       = (sel_adr[31:MEM_AW+2] == '0);
  assign unused_adr_lsb = sel_adr[1:0];
  assign granted_cyc    = gnt_q ? bus.s1_cyc_i : bus.s0_cyc_i;

  // BRAM controls are computed at the grant edge so they are flop outputs for the whole ACCESS cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    err_pend_d = err_pend_q;
    mem_en_d   = 1'b0;
    mem_we_d   = '0;
    mem_addr_d = '0;
    mem_di_d   = '0;
    ack_d      = 2'b00;
    err_d      = 2'b00;

    case (state_q)
      IDLE: begin
        if (|gnt_oh) begin
          state_d    = ACCESS;
          gnt_d      = gnt_oh[1];
          we_d       = sel_we;
          err_pend_d = ~in_range;
          if (in_range) begin
            mem_en_d   = 1'b1;
            mem_we_d   = sel_we ? sel_sel : '0;
            mem_addr_d = sel_adr[MEM_AW+1:2];
            mem_di_d   = sel_dat;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        // A master that abandoned the cycle gets no response, but the access above already happened.
        if (granted_cyc) begin
          if (err_pend_q) begin
            err_d[gnt_q] = 1'b1;
          end else begin
            ack_d[gnt_q] = 1'b1;
          end
        end
      end
      RESP: begin
        state_d    = IDLE;
        last_gnt_d = gnt_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_pend_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      err_pend_q <= err_pend_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_di   = mem_di_q;

  // BRAM read data arrives in RESP, the same cycle the registered ack is high.
  assign bus.s0_ack_o = ack_q[0];
  assign bus.s0_err_o = err_q[0];
  assign bus.s0_dat_o = (ack_q[0] && !we_q) ? bus.mem_do : '0;
  assign bus.s1_ack_o = ack_q[1];
  assign bus.s1_err_o = err_q[1];
  assign bus.s1_dat_o = (ack_q[1] && !we_q) ? bus.mem_do : '0;

endmodule

// File: tb/tb_wb_bram_arb2.sv
// Bench for wb_bram_arb2: directed master transactions with a response scoreboard and a BRAM-access
// scoreboard, both drained by a negedge monitor against a behavioural 512x32 memory.
module tb_wb_bram_arb2;

  typedef struct {
    int          port;
    bit          err;
    bit          rd;
    logic [31:0] dat;
  } rsp_t;

  typedef struct {
    logic [8:0]  addr;
    logic [3:0]  we;
    logic [31:0] di;
  } macc_t;

  logic  clk;
  logic  rst_n;
  int    checks;
  int    errors;
  rsp_t  rsp_q[$];
  macc_t mem_q[$];
  logic [31:0] mem [0:511];

  wb_bram_arb2_if #(.MEM_AW(9)) bus ();

  wb_bram_arb2 #(.MEM_AW(9)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port BRAM, read-before-write, data one clock after the enable edge.
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_di[8*b +: 8];
      end
      bus.mem_do <= mem[bus.mem_addr];
    end
  end

  task automatic exp_rsp(input int p, input bit err, input bit rd, input logic [31:0] dat);
    rsp_t r;
    r.port = p; r.err = err; r.rd = rd; r.dat = dat;
    rsp_q.push_back(r);
  endtask

  task automatic exp_mem(input logic [31:0] byte_adr, input logic [3:0] we, input logic [31:0] di);
    macc_t m;
    m.addr = byte_adr[10:2]; m.we = we; m.di = di;
    mem_q.push_back(m);
  endtask

  task automatic check_port(input int p, input logic ack, input logic err, input logic [31:0] dat);
    rsp_t r;
    logic [31:0] want;
    checks++;
    if (ack || err) begin
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp port%0d: ack=%0b err=%0b dat=%h, required no response", p, ack, err, dat);
      end else begin
        r = rsp_q.pop_front();
        want = (r.rd && !r.err) ? r.dat : 32'h0;
        if (r.port != p || r.err != err || ack == err || dat !== want) begin
          errors++;
          $display("FAIL rsp port%0d: got ack=%0b err=%0b dat=%h, required port%0d %s dat=%h",
                   p, ack, err, dat, r.port, r.err ? "err" : "ack", want);
        end
      end
    end else if (dat !== 32'h0) begin
      errors++;
      $display("FAIL idle_dat port%0d: dat_o=%h, required 00000000", p, dat);
    end
  endtask

  task automatic check_mem();
    macc_t m;
    checks++;
    if (bus.mem_en === 1'b1) begin
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_en: addr=%0d we=%b di=%h, required mem_en=0", bus.mem_addr, bus.mem_we, bus.mem_di);
      end else begin
        m = mem_q.pop_front();
        if (bus.mem_addr !== m.addr || bus.mem_we !== m.we || bus.mem_di !== m.di) begin
          errors++;
          $display("FAIL mem_access: addr=%0d we=%b di=%h, required addr=%0d we=%b di=%h",
                   bus.mem_addr, bus.mem_we, bus.mem_di, m.addr, m.we, m.di);
        end
      end
    end else if (bus.mem_we !== 4'b0) begin
      errors++;
      $display("FAIL mem_we_idle: mem_we=%b with mem_en=%b, required 0000", bus.mem_we, bus.mem_en);
    end
  endtask

  always @(negedge clk) begin
    check_port(0, bus.s0_ack_o, bus.s0_err_o, bus.s0_dat_o);
    check_port(1, bus.s1_ack_o, bus.s1_err_o, bus.s1_dat_o);
    check_mem();
  end

  task automatic check_all_zero(input string name);
    logic [119:0] v;
    v = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_di,
         bus.s0_ack_o, bus.s0_err_o, bus.s0_dat_o, bus.s1_ack_o, bus.s1_err_o, bus.s1_dat_o};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs vector=%h, required all zero", name, v);
    end
  endtask

  task automatic drive(input int p, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (p == 0) begin
      bus.s0_cyc_i = cyc; bus.s0_stb_i = cyc; bus.s0_we_i = we;
      bus.s0_adr_i = adr; bus.s0_sel_i = sel; bus.s0_dat_i = dat;
    end else begin
      bus.s1_cyc_i = cyc; bus.s1_stb_i = cyc; bus.s1_we_i = we;
      bus.s1_adr_i = adr; bus.s1_sel_i = sel; bus.s1_dat_i = dat;
    end
  endtask

  // Holds the request until ack/err is seen, then drops it just after the next rising edge.
  task automatic xfer(input int p, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output int lat);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    drive(p, 1'b1, we, adr, sel, dat);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      done = (p == 0) ? (bus.s0_ack_o | bus.s0_err_o) : (bus.s1_ack_o | bus.s1_err_o);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout port%0d adr=%h: no ack/err within %0d cycles, required one", p, adr, n);
    end
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    lat = n;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat, lat0, lat1;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.mem_do = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: write then read back through port 0, with the uncontended latency
    exp_mem(32'h10, 4'hF, 32'hDEADBEEF);
    exp_rsp(0, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL ack_latency: ack seen at negedge %0d after stb, required 3", lat);
    end
    exp_mem(32'h10, 4'h0, 32'h0);
    exp_rsp(0, 1'b0, 1'b1, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, lat);
    exp_mem(32'h10, 4'h0, 32'h0);
    exp_rsp(1, 1'b0, 1'b1, 32'hDEADBEEF);
    xfer(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, lat);

    // 2: both ports held busy; last grant was port 1, so port 0 leads and they alternate
    exp_mem(32'h20, 4'hF, 32'hA0A0A0A0); exp_rsp(0, 1'b0, 1'b0, 32'h0);
    exp_mem(32'h24, 4'hF, 32'hB0B0B0B0); exp_rsp(1, 1'b0, 1'b0, 32'h0);
    exp_mem(32'h28, 4'hF, 32'hA1A1A1A1); exp_rsp(0, 1'b0, 1'b0, 32'h0);
    exp_mem(32'h2C, 4'hF, 32'hB1B1B1B1); exp_rsp(1, 1'b0, 1'b0, 32'h0);
    fork
      begin
        xfer(0, 1'b1, 32'h20, 4'hF, 32'hA0A0A0A0, lat0);
        xfer(0, 1'b1, 32'h28, 4'hF, 32'hA1A1A1A1, lat0);
      end
      begin
        xfer(1, 1'b1, 32'h24, 4'hF, 32'hB0B0B0B0, lat1);
        xfer(1, 1'b1, 32'h2C, 4'hF, 32'hB1B1B1B1, lat1);
      end
    join
    exp_mem(32'h24, 4'h0, 32'h0);
    exp_rsp(0, 1'b0, 1'b1, 32'hB0B0B0B0);
    xfer(0, 1'b0, 32'h24, 4'hF, 32'h0, lat);

    // 3: out-of-range addresses error with no BRAM enable; last word is still in range
    exp_rsp(1, 1'b1, 1'b0, 32'h0);
    xfer(1, 1'b1, 32'h0000_0800, 4'hF, 32'h12345678, lat);
    exp_rsp(0, 1'b1, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h8000_0000, 4'hF, 32'h0, lat);
    exp_mem(32'h7FC, 4'hF, 32'hCAFEF00D); exp_rsp(0, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h0000_07FC, 4'hF, 32'hCAFEF00D, lat);
    exp_mem(32'h7FC, 4'h0, 32'h0); exp_rsp(1, 1'b0, 1'b1, 32'hCAFEF00D);
    xfer(1, 1'b0, 32'h0000_07FC, 4'hF, 32'h0, lat);

    // 4: byte-lane write, then an all-lanes-off write that must change nothing
    exp_mem(32'h30, 4'hF, 32'h11223344); exp_rsp(0, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h30, 4'hF, 32'h11223344, lat);
    exp_mem(32'h30, 4'b0010, 32'h0000AB00); exp_rsp(0, 1'b0, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h30, 4'b0010, 32'h0000AB00, lat);
    exp_mem(32'h30, 4'b0000, 32'hFFFFFFFF); exp_rsp(1, 1'b0, 1'b0, 32'h0);
    xfer(1, 1'b1, 32'h30, 4'b0000, 32'hFFFFFFFF, lat);
    exp_mem(32'h30, 4'h0, 32'h0); exp_rsp(0, 1'b0, 1'b1, 32'h1122AB44);
    xfer(0, 1'b0, 32'h30, 4'hF, 32'h0, lat);

    // 6: port 0 abandons a write during ACCESS; the write lands but no ack is returned
    exp_mem(32'h40, 4'hF, 32'h5A5A5A5A);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h5A5A5A5A);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (4) @(posedge clk); #1;
    exp_mem(32'h40, 4'h0, 32'h0); exp_rsp(1, 1'b0, 1'b1, 32'h5A5A5A5A);
    xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, lat);

    // 5: port 0 completes last, then a read is aborted by reset during its ACCESS cycle
    exp_mem(32'h10, 4'h0, 32'h0); exp_rsp(0, 1'b0, 1'b1, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lat);
    exp_mem(32'h10, 4'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check_all_zero("reset_mid_access");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_mem(32'h10, 4'h0, 32'h0);  exp_rsp(0, 1'b0, 1'b1, 32'hDEADBEEF);
    exp_mem(32'h7FC, 4'h0, 32'h0); exp_rsp(1, 1'b0, 1'b1, 32'hCAFEF00D);
    fork
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lat0);
      xfer(1, 1'b0, 32'h7FC, 4'hF, 32'h0, lat1);
    join

    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp: %0d expected responses never seen, required 0", rsp_q.size());
    end
    checks++;
    if (mem_q.size() != 0) begin
      errors++;
      $display("FAIL missing_mem: %0d expected BRAM accesses never seen, required 0", mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
